// File: rtl/uart_rx_core_if.sv
// Receive-FIFO read port of uart_rx_core: pop strobe, popped byte and FIFO status.
interface uart_rx_core_if;
  logic       read_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;

  modport master (output read_en, input rd_data, input rd_valid, input full);
  modport slave  (input read_en, output rd_data, output rd_valid, output full);
endinterface

// File: rtl/uart_rx_core.sv
// UART receive front end: synchroniser, mid-bit sampling FSM, receive FIFO and sticky line errors.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each sample point.
module uart_rx_core #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] baud_max_cnt,
  input  logic [1:0]  parity_sel,
  input  logic        stop_sel,
  input  logic        rxd,
  input  logic        err_clr,
  uart_rx_core_if.slave rif,
  output logic        frame_err,
  output logic        parity_err,
  output logic        overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  state_t      state, state_n;
  logic        rxd_s1, rxd_s2, rxd_h;
  logic [15:0] timer;
  logic        samp_raw, decide, bit_val;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        stop1_low;
  logic        shift_en, push, fe_set, pe_set, stop1_low_set;
  logic        par_en, par_odd;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic [7:0]    rd_q;
  logic          do_pop, do_wr, room, ovf_set;

  always_ff @(posedge clock) begin
    if (reset) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
      rxd_h  <= 1'b1;
    end else begin
      rxd_s1 <= rxd;
      rxd_s2 <= rxd_s1;
      rxd_h  <= rxd_s2;
    end
  end

  assign samp_raw = (state == START) ? (timer == (baud_max_cnt >> 1))
                                     : ((state != IDLE) && (timer == baud_max_cnt - 16'd1));

`ifdef UART_RX_MAJORITY_EN
  // Decisions land one cycle after the raw sample point so the +1 sample is available.
  logic rxd_h2, samp_d;
  always_ff @(posedge clock) begin
    if (reset) begin
      rxd_h2 <= 1'b1;
      samp_d <= 1'b0;
    end else begin
      rxd_h2 <= rxd_h;
      samp_d <= samp_raw;
    end
  end
  assign decide  = samp_d;
  assign bit_val = (rxd_s2 & rxd_h) | (rxd_s2 & rxd_h2) | (rxd_h & rxd_h2);
`else
  assign decide  = samp_raw;
  assign bit_val = rxd_s2;
`endif

  // Clearing at the raw START sample keeps later sample points identical in both builds.
  always_ff @(posedge clock) begin
    if (reset || state == IDLE || (state == START && samp_raw))
      timer <= '0;
    else if (timer == baud_max_cnt - 16'd1)
      timer <= '0;
    else
      timer <= timer + 16'd1;
  end

  assign par_en  = (parity_sel == 2'b01) || (parity_sel == 2'b10);
  assign par_odd = (parity_sel == 2'b01);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n       = state;
    shift_en      = 1'b0;
    push          = 1'b0;
    fe_set        = 1'b0;
    pe_set        = 1'b0;
    stop1_low_set = 1'b0;
    unique case (state)
      IDLE:
        if (rxd_h && !rxd_s2) state_n = START;
      START:
        if (decide) state_n = bit_val ? IDLE : DATA;
      DATA:
        if (decide) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_n = par_en ? PARITY : STOP1;
        end
      PARITY:
        if (decide) begin
          pe_set  = (^shreg) ^ bit_val ^ par_odd;
          state_n = STOP1;
        end
      STOP1:
        if (decide) begin
          if (stop_sel) begin
            stop1_low_set = !bit_val;
            state_n       = STOP2;
          end else begin
            fe_set  = !bit_val;
            push    = bit_val;
            state_n = IDLE;
          end
        end
      STOP2:
        if (decide) begin
          fe_set  = !bit_val || stop1_low;
          push    = bit_val && !stop1_low;
          state_n = IDLE;
        end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      stop1_low <= 1'b0;
    end else begin
      if (shift_en) begin
        shreg   <= {bit_val, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end else if (state != DATA) begin
        bit_cnt <= '0;
      end
      if (stop1_low_set)      stop1_low <= 1'b1;
      else if (state == IDLE) stop1_low <= 1'b0;
    end
  end

  // A pop in the same cycle frees a slot, so a push while full is accepted then.
  assign do_pop  = rif.read_en && (count != '0);
  assign room    = (count != DEPTH_CNT) || do_pop;
  assign do_wr   = push && room;
  assign ovf_set = push && !room;

  always_ff @(posedge clock) begin
    if (do_wr) mem[wptr] <= shreg;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      rd_q  <= '0;
    end else begin
      if (do_wr) wptr <= wptr + PTR_ONE;
      if (do_pop) begin
        rd_q <= mem[rptr];
        rptr <= rptr + PTR_ONE;
      end
      unique case ({do_wr, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_err  <= fe_set  | (frame_err  & ~err_clr);
      parity_err <= pe_set  | (parity_err & ~err_clr);
      overflow   <= ovf_set | (overflow   & ~err_clr);
    end
  end

  assign rif.rd_data  = rd_q;
  assign rif.rd_valid = (count != '0);
  assign rif.full     = (count == DEPTH_CNT);

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: directed frames, expected bytes queued at send time.
module tb_uart_rx_core;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] baud_max_cnt;
  logic [1:0]  parity_sel;
  logic        stop_sel;
  logic        rxd;
  logic        err_clr;
  logic        frame_err, parity_err, overflow;

  uart_rx_core_if rif ();

  uart_rx_core #(.FIFO_DEPTH(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .baud_max_cnt (baud_max_cnt),
    .parity_sel   (parity_sel),
    .stop_sel     (stop_sel),
    .rxd          (rxd),
    .err_clr      (err_clr),
    .rif          (rif.slave),
    .frame_err    (frame_err),
    .parity_err   (parity_err),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted pop is compared with the oldest expected byte.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clock);
      if (rif.read_en === 1'b1 && rif.rd_valid === 1'b1) begin
        #1;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop: got 0x%0h, expected no byte", rif.rd_data);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", {24'd0, rif.rd_data}, {24'd0, e});
        end
      end
    end
  end

  task automatic send_bits(input logic [15:0] bits, input int n, input int glitch);
    int b;
    b = int'(baud_max_cnt);
    for (int c = 0; c < n * b; c++) begin
      @(negedge clock);
      rxd = bits[c / b] ^ (c == glitch);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input bit par_flip, input bit stop2_low,
                           input int glitch);
    logic [15:0] fr;
    int n;
    fr = '1;
    fr[0] = 1'b0;
    fr[8:1] = d;
    n = 9;
    if (parity_sel == 2'b01 || parity_sel == 2'b10) begin
      fr[9] = ((parity_sel == 2'b10) ? (^d) : ~(^d)) ^ par_flip;
      n = 10;
    end
    fr[n] = 1'b1;
    n++;
    if (stop_sel) begin
      fr[n] = ~stop2_low;
      n++;
    end
    send_bits(fr, n, glitch);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clock);
  endtask

  task automatic pop();
    @(negedge clock);
    rif.read_en = 1'b1;
    @(negedge clock);
    rif.read_en = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clock);
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
  endtask

  initial begin
    logic [7:0] glitch_exp;
    reset        = 1'b1;
    rxd          = 1'b1;
    err_clr      = 1'b0;
    rif.read_en  = 1'b0;
    baud_max_cnt = 16'd868;
    parity_sel   = 2'b00;
    stop_sel     = 1'b0;
    idle(4);
    reset = 1'b0;
    idle(2);

    check("reset_rd_data",    {24'd0, rif.rd_data}, 32'h00);
    check("reset_rd_valid",   {31'd0, rif.rd_valid}, 32'd0);
    check("reset_full",       {31'd0, rif.full}, 32'd0);
    check("reset_frame_err",  {31'd0, frame_err}, 32'd0);
    check("reset_parity_err", {31'd0, parity_err}, 32'd0);
    check("reset_overflow",   {31'd0, overflow}, 32'd0);

    // Basic receive at 868 cycles/bit
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b0, 1'b0, -1);
    idle(4);
    check("basic_rd_valid",   {31'd0, rif.rd_valid}, 32'd1);
    check("basic_frame_err",  {31'd0, frame_err}, 32'd0);
    check("basic_parity_err", {31'd0, parity_err}, 32'd0);
    check("basic_overflow",   {31'd0, overflow}, 32'd0);
    pop();
    check("basic_empty_after_pop", {31'd0, rif.rd_valid}, 32'd0);
    pop();
    check("empty_pop_holds", {24'd0, rif.rd_data}, 32'h55);

    // Even parity with a forced-bad parity bit: byte still queued
    baud_max_cnt = 16'd32;
    parity_sel   = 2'b10;
    exp_q.push_back(8'hA3);
    send_byte(8'hA3, 1'b1, 1'b0, -1);
    idle(4);
    check("par_err_set",   {31'd0, parity_err}, 32'd1);
    check("par_rd_valid",  {31'd0, rif.rd_valid}, 32'd1);
    pulse_clr();
    check("par_err_clr",   {31'd0, parity_err}, 32'd0);
    pop();

    // Odd parity, correct parity bit
    parity_sel = 2'b01;
    exp_q.push_back(8'h07);
    send_byte(8'h07, 1'b0, 1'b0, -1);
    idle(4);
    check("odd_par_ok", {31'd0, parity_err}, 32'd0);
    pop();
    parity_sel = 2'b00;

    // Frame error on second stop bit, then line held low for 20 bits
    stop_sel = 1'b1;
    send_byte(8'h3C, 1'b0, 1'b1, -1);
    idle(20 * 32);
    check("frame_err_set",    {31'd0, frame_err}, 32'd1);
    check("frame_fifo_empty", {31'd0, rif.rd_valid}, 32'd0);
    @(negedge clock);
    rxd = 1'b1;
    idle(3 * 32);
    check("held_low_no_push", {31'd0, rif.rd_valid}, 32'd0);
    pulse_clr();
    check("frame_err_clr",    {31'd0, frame_err}, 32'd0);
    stop_sel = 1'b0;

    // Overflow: 17 bytes back to back, last one dropped
    baud_max_cnt = 16'd16;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b0, 1'b0, -1);
      if (i == 14) check("not_full_15", {31'd0, rif.full}, 32'd0);
      if (i == 15) begin
        check("full_16",    {31'd0, rif.full}, 32'd1);
        check("no_ovf_16",  {31'd0, overflow}, 32'd0);
      end
    end
    idle(4);
    check("ovf_17",  {31'd0, overflow}, 32'd1);
    check("full_17", {31'd0, rif.full}, 32'd1);
    for (int i = 0; i < 16; i++) pop();
    check("drained_valid", {31'd0, rif.rd_valid}, 32'd0);
    check("drained_full",  {31'd0, rif.full}, 32'd0);
    pulse_clr();
    check("ovf_clr", {31'd0, overflow}, 32'd0);

    // False start: 400-cycle low pulse at 868 cycles/bit
    baud_max_cnt = 16'd868;
    @(negedge clock);
    rxd = 1'b0;
    idle(400);
    rxd = 1'b1;
    idle(100);
    check("false_start_no_push", {31'd0, rif.rd_valid}, 32'd0);
    exp_q.push_back(8'hFF);
    send_byte(8'hFF, 1'b0, 1'b0, -1);
    idle(4);
    check("after_false_valid", {31'd0, rif.rd_valid}, 32'd1);
    pop();

    // One-cycle glitch on data bit 3 exactly at its sample point
    baud_max_cnt = 16'd64;
`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'h00;
`else
    glitch_exp = 8'h08;
`endif
    exp_q.push_back(glitch_exp);
    send_byte(8'h00, 1'b0, 1'b0, 32 + 1 + 4 * 64);
    idle(4);
    check("glitch_valid", {31'd0, rif.rd_valid}, 32'd1);
    pop();

    // Reset in the middle of a frame abandons it
    baud_max_cnt = 16'd32;
    send_bits(16'h0000, 5, -1);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    rxd   = 1'b1;
    idle(3 * 32);
    check("midframe_reset_no_push", {31'd0, rif.rd_valid}, 32'd0);
    check("midframe_reset_no_ferr", {31'd0, frame_err}, 32'd0);

    idle(4);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
